// File: rtl/sc_lives_hit_generator.sv
// sc_lives_hit_generator: turns the collision level into one-cycle upcount pulses, with invulnerability, game-over and restart.
// Define SC_LIVES_HIT_BLINK_EN to flash the sprite during invulnerability; otherwise blink = ~gameOver.
module sc_lives_hit_generator #(
  parameter int LIVES_COUNTER_DATAWIDTH = 3,
  parameter int MAX_LIVES = 3,
  parameter int INVULN_DATAWIDTH = 24,
  parameter int INVULN_CYCLES = 12500000,
  parameter int BLINK_SHIFT = 20
) (
  input  logic                               SC_LIVES_HIT_CLOCK_50,
  input  logic                               SC_LIVES_HIT_RESET_InLow,
  input  logic                               SC_LIVES_HIT_collision_InHigh,
  input  logic                               SC_LIVES_HIT_restart_InLow,
  input  logic [LIVES_COUNTER_DATAWIDTH-1:0] SC_LIVES_HIT_livesUsed_In,
  output logic                               SC_LIVES_HIT_upcount_OutLow,
  output logic                               SC_LIVES_HIT_counterReset_OutHigh,
  output logic                               SC_LIVES_HIT_invulnerable_OutHigh,
  output logic                               SC_LIVES_HIT_gameOver_OutHigh,
  output logic                               SC_LIVES_HIT_blink_OutHigh,
  output logic [LIVES_COUNTER_DATAWIDTH-1:0] SC_LIVES_HIT_livesLeft_Out
);
  typedef enum logic [2:0] {PLAY, HIT, WAIT_ACK, INVULN, GAME_OVER, RESTART} state_t;
  localparam logic [LIVES_COUNTER_DATAWIDTH-1:0] MAX_L = LIVES_COUNTER_DATAWIDTH'(MAX_LIVES);
  localparam logic [INVULN_DATAWIDTH-1:0] LOAD = INVULN_DATAWIDTH'(INVULN_CYCLES - 1);
  state_t r_state, w_next;
  logic [INVULN_DATAWIDTH-1:0] r_timer;
  logic r_col_q, r_upcount, r_cnt_rst, r_invuln, r_over, r_blink;
  logic w_hit, w_dead;
  assign w_hit  = SC_LIVES_HIT_collision_InHigh & ~r_col_q;
  assign w_dead = SC_LIVES_HIT_livesUsed_In >= MAX_L;
  // Restart overrides every other transition, including the game-over check.
  always_comb begin
    w_next = r_state;
    if (!SC_LIVES_HIT_restart_InLow) w_next = RESTART;
    else
      case (r_state)
        PLAY:      w_next = w_dead ? GAME_OVER : (w_hit ? HIT : PLAY);
        HIT:       w_next = WAIT_ACK;
        WAIT_ACK:  w_next = w_dead ? GAME_OVER : INVULN;
        INVULN:    w_next = (r_timer == '0) ? PLAY : INVULN;
        GAME_OVER: w_next = GAME_OVER;
        default:   w_next = PLAY;
      endcase
  end
  always_ff @(posedge SC_LIVES_HIT_CLOCK_50 or negedge SC_LIVES_HIT_RESET_InLow)
    if (!SC_LIVES_HIT_RESET_InLow) begin
      r_state   <= PLAY;
      r_timer   <= '0;
      r_col_q   <= 1'b0;
      r_upcount <= 1'b1;
      r_cnt_rst <= 1'b0;
      r_invuln  <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_col_q   <= SC_LIVES_HIT_collision_InHigh;
      r_timer   <= (w_next == INVULN && r_state != INVULN) ? LOAD :
                   (r_state == INVULN && r_timer != '0) ? r_timer - 1'b1 : r_timer;
      r_upcount <= w_next != HIT;
      r_cnt_rst <= w_next == RESTART;
      r_invuln  <= w_next == INVULN;
      r_over    <= w_next == GAME_OVER;
    end
`ifdef SC_LIVES_HIT_BLINK_EN
  logic [BLINK_SHIFT:0] r_bcnt, w_bcnt;
  assign w_bcnt = (r_state == INVULN) ? r_bcnt + 1'b1 : '0;
  always_ff @(posedge SC_LIVES_HIT_CLOCK_50 or negedge SC_LIVES_HIT_RESET_InLow)
    if (!SC_LIVES_HIT_RESET_InLow) begin
      r_bcnt  <= '0;
      r_blink <= 1'b0;
    end else begin
      r_bcnt  <= w_bcnt;
      r_blink <= (w_next == INVULN) ? ~w_bcnt[BLINK_SHIFT] : (w_next != GAME_OVER);
    end
`else
  always_ff @(posedge SC_LIVES_HIT_CLOCK_50 or negedge SC_LIVES_HIT_RESET_InLow)
    if (!SC_LIVES_HIT_RESET_InLow) r_blink <= 1'b0;
    else r_blink <= w_next != GAME_OVER;
`endif
  assign SC_LIVES_HIT_upcount_OutLow       = r_upcount;
  assign SC_LIVES_HIT_counterReset_OutHigh = r_cnt_rst;
  assign SC_LIVES_HIT_invulnerable_OutHigh = r_invuln;
  assign SC_LIVES_HIT_gameOver_OutHigh     = r_over;
  assign SC_LIVES_HIT_blink_OutHigh        = r_blink;
  assign SC_LIVES_HIT_livesLeft_Out        = w_dead ? '0 : MAX_L - SC_LIVES_HIT_livesUsed_In;
endmodule

// File: tb/tb_sc_lives_hit_generator.sv
// tb_sc_lives_hit_generator: lives-counter loop around the hit generator, checked against a hit-sequence model.
module tb_sc_lives_hit_generator;
  localparam int LW = 3, MAXL = 3, INV = 8, BS = 1;
  logic clk = 0, rst_n = 1, col = 0, restart = 1;
  logic [LW-1:0] used, left;
  logic upc, crst, inv, over, blink;
  logic [10:0] obs;
  int n_chk = 0, n_fail = 0;
  int m_phase, m_used;
  bit m_over, m_rst, m_colq, m_bv;

  always #5 clk = ~clk;

  sc_lives_hit_generator #(.LIVES_COUNTER_DATAWIDTH(LW), .MAX_LIVES(MAXL), .INVULN_DATAWIDTH(4),
                           .INVULN_CYCLES(INV), .BLINK_SHIFT(BS)) dut (
    .SC_LIVES_HIT_CLOCK_50(clk), .SC_LIVES_HIT_RESET_InLow(rst_n),
    .SC_LIVES_HIT_collision_InHigh(col), .SC_LIVES_HIT_restart_InLow(restart),
    .SC_LIVES_HIT_livesUsed_In(used), .SC_LIVES_HIT_upcount_OutLow(upc),
    .SC_LIVES_HIT_counterReset_OutHigh(crst), .SC_LIVES_HIT_invulnerable_OutHigh(inv),
    .SC_LIVES_HIT_gameOver_OutHigh(over), .SC_LIVES_HIT_blink_OutHigh(blink),
    .SC_LIVES_HIT_livesLeft_Out(left));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) used <= '0;
    else if (crst) used <= '0;
    else if (!upc) used <= used + 1'b1;

  assign obs = {upc, crst, inv, over, blink, left, used};

  // m_phase: -1 idle, 0 the pulse cycle, 1 the ack cycle, 2..INV+1 the invulnerable cycles.
  task automatic model_reset();
    m_phase = -1; m_used = 0; m_over = 0; m_rst = 0; m_colq = 0; m_bv = 0;
  endtask

  task automatic model_step();
    bit hit;
    int u;
    hit = col && !m_colq; m_colq = col; u = m_used; m_bv = 1;
    if (m_rst) m_used = 0; else if (m_phase == 0) m_used++;
    if (!restart) begin m_rst = 1; m_phase = -1; m_over = 0; end
    else if (m_rst) m_rst = 0;
    else if (m_over) m_over = 1;
    else if (m_phase == -1) begin
      if (u >= MAXL) m_over = 1; else if (hit) m_phase = 0;
    end else if (m_phase == 1) begin
      if (u >= MAXL) begin m_over = 1; m_phase = -1; end else m_phase = 2;
    end else m_phase = (m_phase == INV + 1) ? -1 : m_phase + 1;
  endtask

  function automatic logic e_blink();
    if (!m_bv) return 1'b0;
`ifdef SC_LIVES_HIT_BLINK_EN
    if (m_phase >= 2) return (((m_phase - 2) >> BS) % 2) == 0;
`endif
    return !m_over;
  endfunction

  function automatic logic [10:0] exp_vec();
    int l;
    l = (m_used >= MAXL) ? 0 : MAXL - m_used;
    return {m_phase != 0, m_rst, m_phase >= 2, m_over, e_blink(), LW'(l), LW'(m_used)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 0; model_reset();
    tick(); tick();
    n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_values got %b want %b", obs, exp_vec()); end
    #2 rst_n = 1;
    repeat (3) tick();
    n_chk++; if ({upc, left, over, crst, blink} !== {1'b1, 3'd3, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL post_reset_idle got %b want %b", {upc, left, over, crst, blink}, 7'b1011001); end
  endtask

  task automatic test_single_hit();
    int pulses = 0, inv_cyc = 0;
    col = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      pulses += !upc; inv_cyc += inv;
      n_chk++; if (upc !== (i != 1) || inv !== (i >= 3 && i <= 10)) begin
        n_fail++; $display("FAIL single_hit_timing cyc %0d got upc=%b inv=%b", i, upc, inv); end
`ifdef SC_LIVES_HIT_BLINK_EN
      if (i >= 3 && i <= 10) begin
        n_chk++; if (blink !== ((((i - 3) >> 1) % 2) == 0)) begin n_fail++; $display("FAIL blink_toggle cyc %0d got %b", i, blink); end
      end
`endif
      n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL single_hit_model got %b want %b", obs, exp_vec()); end
    end
    n_chk++; if ({pulses[3:0], inv_cyc[3:0], used, left} !== {4'd1, 4'd8, 3'd1, 3'd2}) begin
      n_fail++; $display("FAIL single_hit_totals got pulses=%0d inv=%0d used=%0d left=%0d want 1 8 1 2", pulses, inv_cyc, used, left); end
    col = 0; tick();
  endtask

  task automatic test_invuln_ignore();
    col = 1; tick(); col = 0;
    repeat (3) tick();
    col = 1; tick(); col = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_chk++; if (upc !== 1'b1 || obs !== exp_vec()) begin n_fail++; $display("FAIL invuln_ignore got %b want %b", obs, exp_vec()); end
    end
    n_chk++; if (used !== 3'd2 || left !== 3'd1) begin n_fail++; $display("FAIL invuln_ignore_count got used=%0d left=%0d want 2 1", used, left); end
  endtask

  task automatic test_game_over();
    col = 1; tick(); col = 0;
    repeat (2) tick();
    n_chk++; if ({over, inv, left, used, blink} !== {1'b1, 1'b0, 3'd0, 3'd3, 1'b0}) begin
      n_fail++; $display("FAIL game_over_entry got over=%b inv=%b left=%0d used=%0d blink=%b", over, inv, left, used, blink); end
    for (int i = 0; i < 16; i++) begin
      col = i[1]; tick();
      n_chk++; if (upc !== 1'b1 || over !== 1'b1 || obs !== exp_vec()) begin n_fail++; $display("FAIL game_over_hold got %b want %b", obs, exp_vec()); end
    end
    col = 0; tick();
  endtask

  task automatic test_restart();
    restart = 0; tick(); restart = 1;
    n_chk++; if (crst !== 1'b1 || over !== 1'b0) begin n_fail++; $display("FAIL restart_pulse got crst=%b over=%b want 1 0", crst, over); end
    tick();
    n_chk++; if ({crst, used, left, over} !== {1'b0, 3'd0, 3'd3, 1'b0}) begin
      n_fail++; $display("FAIL restart_play got crst=%b used=%0d left=%0d over=%b", crst, used, left, over); end
  endtask

  task automatic test_restart_vs_hit();
    col = 1; restart = 0; tick(); restart = 1;
    n_chk++; if (crst !== 1'b1 || upc !== 1'b1) begin n_fail++; $display("FAIL restart_priority got crst=%b upc=%b want 1 1", crst, upc); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (upc !== 1'b1 || used !== 3'd0 || obs !== exp_vec()) begin n_fail++; $display("FAIL restart_no_pulse got %b want %b", obs, exp_vec()); end
    end
    col = 0; tick();
  endtask

  task automatic test_restart_held();
    restart = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (crst !== 1'b1) begin n_fail++; $display("FAIL restart_held cyc %0d got crst=%b want 1", i, crst); end
    end
    restart = 1; tick();
    n_chk++; if (crst !== 1'b0 || obs !== exp_vec()) begin n_fail++; $display("FAIL restart_release got %b want %b", obs, exp_vec()); end
  endtask

  task automatic test_async_reset();
    col = 1; tick(); col = 0;
    repeat (4) tick();
    n_chk++; if (inv !== 1'b1) begin n_fail++; $display("FAIL async_pre got inv=%b want 1", inv); end
    #2 rst_n = 0; model_reset();
    #1;
    n_chk++; if ({upc, crst, inv, over, blink, used} !== {5'b10000, 3'd0}) begin
      n_fail++; $display("FAIL async_mid_invuln got %b want 10000000", {upc, crst, inv, over, blink, used}); end
    tick(); rst_n = 1;
    tick(); col = 1; tick(); col = 0;
    n_chk++; if (upc !== 1'b0) begin n_fail++; $display("FAIL async_hit_pre got upc=%b want 0", upc); end
    #2 rst_n = 0; model_reset();
    #1;
    n_chk++; if (upc !== 1'b1 || used !== 3'd0) begin n_fail++; $display("FAIL async_mid_hit got upc=%b used=%0d want 1 0", upc, used); end
    tick(); rst_n = 1;
    repeat (2) tick();
    n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL async_recover got %b want %b", obs, exp_vec()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) col = ~col;
      restart = ($urandom_range(0, 60) != 0);
      tick();
      n_chk++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL random cyc %0d got %b want %b", i, obs, exp_vec()); end
    end
    restart = 1; col = 0;
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_invuln_ignore();
    test_game_over();
    test_restart();
    test_restart_vs_hit();
    test_restart_held();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
